date_loader: RTL
================

DATE_LOADER -- requirements
Module: date_loader

Interface
REQ-001 Parameter SETTLE, default 2: idle cycles after each up pulse before date_count is re-sampled (1..15).
REQ-002 Parameter YEAR_MAX_PULSES, default 16384: year-phase pulse limit before error.
REQ-003 clock  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low; clears all state.
REQ-005 start  input  1  one-cycle request; begin loading target_date.
REQ-006 target_date  input  23  packed {year[22:9], month[8:5], day[4:0]}, binary.
REQ-007 date_count  input  23  live calendar value, same packing as target_date.
REQ-008 up  output  5  one-cycle increment pulses: up[0] day, up[1] month, up[2] year+1; up[4:3] always 0.
REQ-009 set  output  2  set[1] = calendar edit mode; set[0] = day-edit select.
REQ-010 busy  output  1  high from the cycle after accepted start until done or error.
REQ-011 done  output  1  one-cycle pulse on successful load.
REQ-012 error  output  1  held high after a failed load until the next accepted start or reset.

Function
REQ-013 start SHALL be accepted only in IDLE; on acceptance target_date is latched and error is cleared; start while busy is ignored.
REQ-014 States SHALL be IDLE, ENTER, CHECK, PULSE, WAIT, VERIFY, DONE, FAIL; phase register SHALL sequence YEAR -> MONTH -> DAY.
REQ-015 ENTER SHALL assert set[1] and hold for SETTLE cycles before the first CHECK.
REQ-016 CHECK SHALL compare the current phase field of date_count with the latched target field: equal -> next phase (after DAY -> VERIFY); unequal -> PULSE.
REQ-017 PULSE SHALL assert exactly one up bit for one cycle (the current phase's bit) and increment the phase pulse counter; WAIT then holds SETTLE cycles and returns to CHECK.
REQ-018 The pulse counter SHALL clear on each phase change; the limit SHALL be YEAR_MAX_PULSES for YEAR, 12 for MONTH, 31 for DAY; reaching the limit with a mismatch in CHECK -> FAIL.
REQ-019 set[1] SHALL be 1 from ENTER through VERIFY; set[0] SHALL be 1 only during DAY phase; set = 2'b00 in IDLE, DONE, FAIL.
REQ-020 DONE SHALL last one cycle, pulse done, and return to IDLE; FAIL SHALL last one cycle, set error, and return to IDLE.
REQ-021 At most one up bit SHALL be high in any cycle; up = 0 outside PULSE.
REQ-022 Pulse limits prevent deadlock when a target is unreachable (e.g. day 30 in February, month 0 or 13, day 0).

Reset
REQ-023 reset low SHALL force IDLE, phase YEAR, counters 0, latched target 0, up = 0, set = 0, busy = 0, done = 0, error = 0 immediately, including mid-operation.
REQ-024 Operation after reset release SHALL begin only on a new start.

Configuration
REQ-025 Macro DATE_LOADER_VERIFY_EN defined: VERIFY SHALL wait SETTLE cycles, then compare all 23 bits of date_count with the target; equal -> DONE, unequal -> FAIL.
REQ-026 Macro undefined: VERIFY SHALL pass straight to DONE in one cycle with no comparison.

Verification
REQ-027 Calendar model at 2024/01/01, start with target 2024/03/15 -> 0 year pulses, 2 up[1] pulses, 14 up[0] pulses, set[0] high only in DAY phase, one done pulse, error 0.
REQ-028 Model at 2023/01/01, target 2024/02/29 -> 1 up[2] pulse, 1 up[1], 28 up[0], done; February limit of 29 days respected.
REQ-029 Model at 2023/02/01, target 2023/02/30 -> 31 up[0] pulses with no match, then error = 1, busy = 0, no done.
REQ-030 reset low during MONTH phase WAIT -> all outputs 0 within the same cycle; new start afterwards restarts from YEAR phase.
REQ-031 start pulsed again while busy with target 2000/01/01 -> ignored; the original target completes unchanged.
REQ-032 With DATE_LOADER_VERIFY_EN, model forces month +1 during DAY phase -> VERIFY mismatch, error = 1; without the macro, the same stimulus -> done.

Source files
------------

// File: rtl/date_loader_if.sv
// Request/response and calendar-edit bundle for date_loader.
// master: drives start, target_date, date_count; slave: drives up, set, busy, done, error.
interface date_loader_if;
  logic        start;
  logic [22:0] target_date;
  logic [22:0] date_count;
  logic [4:0]  up;
  logic [1:0]  set;
  logic        busy;
  logic        done;
  logic        error;

  modport master (
    output start, target_date, date_count,
    input  up, set, busy, done, error
  );

  modport slave (
    input  start, target_date, date_count,
    output up, set, busy, done, error
  );
endinterface

// File: rtl/date_loader.sv
// Steps a live calendar to target_date via year/month/day up pulses.
// Ports: clock, reset (async active-low), bus (date_loader_if.slave).
// Option: DATE_LOADER_VERIFY_EN adds a settled full-date compare before done.
module date_loader #(
  parameter int SETTLE          = 2,
  parameter int YEAR_MAX_PULSES = 16384
) (
  input  logic clock,
  input  logic reset,
  date_loader_if.slave bus
);

  localparam int PCB = $clog2(YEAR_MAX_PULSES + 1);
  localparam int PCW = (PCB > 5) ? PCB : 5;

  localparam logic [3:0]     WLAST = 4'(SETTLE - 1);
  localparam logic [PCW-1:0] LIM_Y = PCW'(YEAR_MAX_PULSES);
  localparam logic [PCW-1:0] LIM_M = PCW'(12);
  localparam logic [PCW-1:0] LIM_D = PCW'(31);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTER,
    S_CHECK,
    S_PULSE,
    S_WAIT,
    S_VERIFY,
    S_DONE,
    S_FAIL
  } state_t;

  typedef enum logic [1:0] {
    P_YEAR,
    P_MONTH,
    P_DAY
  } phase_t;

  state_t         state_q, state_d;
  phase_t         phase_q, phase_d;
  logic [3:0]     wcnt_q, wcnt_d;
  logic [PCW-1:0] pcnt_q, pcnt_d;
  logic [22:0]    tgt_q;
  logic           err_q;

  logic           accept;
  logic           hit;
  logic [PCW-1:0] lim;
  logic           edit;

  assign accept = (state_q == S_IDLE) && bus.start;

  // Field under edit and its pulse budget.
  always_comb begin
    hit = 1'b0;
    lim = LIM_D;
    unique case (phase_q)
      P_YEAR: begin
        hit = bus.date_count[22:9] == tgt_q[22:9];
        lim = LIM_Y;
      end
      P_MONTH: begin
        hit = bus.date_count[8:5] == tgt_q[8:5];
        lim = LIM_M;
      end
      P_DAY: begin
        hit = bus.date_count[4:0] == tgt_q[4:0];
        lim = LIM_D;
      end
      default: begin
        hit = 1'b0;
        lim = LIM_D;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    wcnt_d  = wcnt_q;
    pcnt_d  = pcnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_ENTER;
          phase_d = P_YEAR;
          wcnt_d  = '0;
          pcnt_d  = '0;
        end
      end
      S_ENTER, S_WAIT: begin
        if (wcnt_q == WLAST) begin
          state_d = S_CHECK;
          wcnt_d  = '0;
        end else begin
          wcnt_d = wcnt_q + 4'd1;
        end
      end
      S_CHECK: begin
        if (hit) begin
          pcnt_d = '0;
          unique case (phase_q)
            P_YEAR:  phase_d = P_MONTH;
            P_MONTH: phase_d = P_DAY;
            default: begin
              state_d = S_VERIFY;
              wcnt_d  = '0;
            end
          endcase
        end else if (pcnt_q >= lim) begin
          state_d = S_FAIL;
        end else begin
          state_d = S_PULSE;
        end
      end
      S_PULSE: begin
        pcnt_d  = pcnt_q + PCW'(1);
        state_d = S_WAIT;
        wcnt_d  = '0;
      end
      S_VERIFY: begin
`ifdef DATE_LOADER_VERIFY_EN
        if (wcnt_q == WLAST) begin
          wcnt_d  = '0;
          state_d = (bus.date_count == tgt_q)
                  ? S_DONE : S_FAIL;
        end else begin
          wcnt_d = wcnt_q + 4'd1;
        end
`else
        state_d = S_DONE;
`endif
      end
      S_DONE, S_FAIL: begin
        state_d = S_IDLE;
        phase_d = P_YEAR;
        pcnt_d  = '0;
        wcnt_d  = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Edit mode spans ENTER..VERIFY; busy is the same window.
  assign edit = (state_q == S_ENTER)
             || (state_q == S_CHECK)
             || (state_q == S_PULSE)
             || (state_q == S_WAIT)
             || (state_q == S_VERIFY);

  always_comb begin
    bus.up = '0;
    if (state_q == S_PULSE) begin
      unique case (1'b1)
        phase_q == P_YEAR:  bus.up[2] = 1'b1;
        phase_q == P_MONTH: bus.up[1] = 1'b1;
        phase_q == P_DAY:   bus.up[0] = 1'b1;
        default:            bus.up    = '0;
      endcase
    end
  end

  assign bus.set   = {edit, edit && (phase_q == P_DAY)};
  assign bus.busy  = edit;
  assign bus.done  = (state_q == S_DONE);
  assign bus.error = err_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      phase_q <= P_YEAR;
      wcnt_q  <= '0;
      pcnt_q  <= '0;
      tgt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      wcnt_q  <= wcnt_d;
      pcnt_q  <= pcnt_d;
      if (accept) begin
        tgt_q <= bus.target_date;
        err_q <= 1'b0;
      end else if (state_d == S_FAIL) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule
